// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM generator: output alignment mode
// and the counting direction of the shared timebase.
package pwm_pkg;

    // Alignment of the PWM pulses within a period.
    typedef enum logic {
        PWM_EDGE   = 1'b0,  // sawtooth counter, pulse starts at the period boundary
        PWM_CENTER = 1'b1   // triangle counter, pulse centred on the counter bottom
    } pwm_mode_e;

    // Direction of the shared counter.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: period/mode shadow and active registers, the up or
// up/down counter, the period boundary detection and the registered
// period-start strobe. All channels compare against the cnt produced here.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int          WIDTH      = 10,
    parameter int unsigned PERIOD_RST = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] period_i,
    input  logic             period_we,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary,
    output logic             load,
    output logic             period_start
);

    logic [WIDTH-1:0] period_shadow;
    logic [WIDTH-1:0] period_active;
    pwm_mode_e        mode_active;
    pwm_dir_e         dir;

    logic [WIDTH-1:0] period_eff;
    pwm_mode_e        mode_eff;
    logic [WIDTH-1:0] cnt_next;
    pwm_dir_e         dir_next;

    // Boundary detection, effective period/mode and next counter state.
    // The effective values are the ones that will be active for the step
    // being taken, so a period starting at the boundary already counts with
    // its new period and mode on its very first step.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        cnt_next   = '0;
        dir_next   = DIR_UP;
        boundary   = en && (cnt == '0) && (dir == DIR_UP);
        load       = !en || boundary;
        period_eff = load ? period_shadow : period_active;
        mode_eff   = load ? pwm_mode_e'(mode) : mode_active;

        if (en) begin
            if (mode_eff == PWM_EDGE) begin
                // Sawtooth 0..period, then wrap.
                cnt_next = (cnt == period_eff) ? '0 : cnt + WIDTH'(1);
            end else if (period_eff != '0) begin
                // Triangle 0..period..1, the next 0 starts a new period.
                if ((dir == DIR_UP) && (cnt != period_eff)) begin
                    cnt_next = cnt + WIDTH'(1);
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                    dir_next = (cnt_next == '0) ? DIR_UP : DIR_DOWN;
                end
            end
            // Centre mode with a zero period holds cnt at 0, direction up.
        end
    end

    // Shadow writes, boundary loads of the active registers, counter state
    // and the period-start strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_shadow <= WIDTH'(PERIOD_RST);
            period_active <= WIDTH'(PERIOD_RST);
            mode_active   <= PWM_EDGE;
            cnt           <= '0;
            dir           <= DIR_UP;
            period_start  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, e.g. the active period
            // loads the shadow as it was before a same-cycle write.
            if (period_we) begin
                period_shadow <= period_i;
            end
            if (load) begin
                period_active <= period_eff;
                mode_active   <= mode_eff;
            end
            cnt          <= cnt_next;
            dir          <= dir_next;
            period_start <= boundary;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM generator sharing one timebase. Each channel owns a duty
// shadow written by its strobe and a duty active register loaded at the
// period boundary (or continuously while disabled), and a registered
// comparator producing its output bit.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int          WIDTH      = 10,
    parameter int          NCH        = 2,
    parameter int unsigned PERIOD_RST = (2 ** WIDTH) - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     period_i,
    input  logic                 period_we,
    input  logic [NCH*WIDTH-1:0] duty_i,
    input  logic [NCH-1:0]       duty_we,
    output logic [NCH-1:0]       pwm_o,
    output logic                 period_start_o
);

    logic [WIDTH-1:0] cnt;
    logic             boundary;
    logic             load;

    pwm_timebase #(
        .WIDTH      (WIDTH),
        .PERIOD_RST (PERIOD_RST)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .period_i     (period_i),
        .period_we    (period_we),
        .cnt          (cnt),
        .boundary     (boundary),
        .load         (load),
        .period_start (period_start_o)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] duty_shadow;
        logic [WIDTH-1:0] duty_active;
        logic [WIDTH-1:0] duty_eff;
        logic             pwm_bit;

        // Duty in force for this cycle's compare: the shadow when the
        // active register is being reloaded, so the first output cycle of a
        // period already reflects the new duty.
        always_comb begin
            duty_eff = load ? duty_shadow : duty_active;
        end

        // Duty double buffer and registered compare against the timebase.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the duty registers are a handful of flops, not a
                // memory, so they reset like any other state.
                duty_shadow <= '0;
                duty_active <= '0;
                pwm_bit     <= 1'b0;
            end else begin
                if (duty_we[k]) begin
                    duty_shadow <= duty_i[k*WIDTH +: WIDTH];
                end
                if (load) begin
                    duty_active <= duty_eff;
                end
                pwm_bit <= en & (cnt < duty_eff);
            end
        end

        assign pwm_o[k] = pwm_bit;
    end

endmodule
